// File: rtl/mips_muldiv_unit_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
// The master drives requests; the slave (the unit) returns status and HI/LO.
interface mips_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [2:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_flush;
  logic             o_busy;
  logic             o_done;
  logic             o_div_by_zero;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport master (
    output i_start, i_op, i_a, i_b, i_flush,
    input  o_busy, o_done, o_div_by_zero, o_hi, o_lo
  );

  modport slave (
    input  i_start, i_op, i_a, i_b, i_flush,
    output o_busy, o_done, o_div_by_zero, o_hi, o_lo
  );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit owning the architectural HI/LO registers.
// One shift-add (multiply) or restoring-subtract (divide) step per cycle on operand magnitudes.
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mips_muldiv_unit_if.slave       bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_isDiv;
  logic                 r_negRes;
  logic                 r_negRem;
  logic                 r_bZero;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_dbz;

  logic                 w_accept;
  logic                 w_step;
  logic                 w_finish;
  logic                 w_mthi;
  logic                 w_mtlo;

  logic                 w_signed;
  logic                 w_opDiv;
  logic                 w_aNeg;
  logic                 w_bNeg;
  logic [WIDTH-1:0]     w_absA;
  logic [WIDTH-1:0]     w_absB;
  logic [WIDTH:0]       w_addSum;
  logic [WIDTH:0]       w_remShift;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_prodFix;
  logic [WIDTH-1:0]     w_quoFix;
  logic [WIDTH-1:0]     w_remFix;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    w_mthi   = 1'b0;
    w_mtlo   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          case (bus.i_op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
              w_accept = 1'b1;
              w_next   = CALC;
            end
            3'b100:  w_mthi = 1'b1;
            3'b101:  w_mtlo = 1'b1;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (bus.i_flush) begin
          w_next = IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            w_next = FIX;
          end
        end
      end
      FIX: begin
        // Flush wins over completion so an aborted op never touches HI/LO.
        w_next = IDLE;
        if (!bus.i_flush) begin
          w_finish = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_signed   = ~bus.i_op[0];
    w_opDiv    = bus.i_op[1];
    w_aNeg     = w_signed & bus.i_a[WIDTH-1];
    w_bNeg     = w_signed & bus.i_b[WIDTH-1];
    w_absA     = w_aNeg ? -bus.i_a : bus.i_a;
    w_absB     = w_bNeg ? -bus.i_b : bus.i_b;
    w_addSum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff     = w_remShift - {1'b0, r_opnd};
    w_prodFix  = r_negRes ? -r_acc : r_acc;
    w_quoFix   = r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_remFix   = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  end

  // Multiply keeps the multiplier in the low half; divide keeps dividend/quotient there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_isDiv  <= 1'b0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_bZero  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_cnt    <= CNT_W'(WIDTH);
        r_isDiv  <= w_opDiv;
        r_negRes <= w_aNeg ^ w_bNeg;
        r_negRem <= w_aNeg;
        r_bZero  <= (bus.i_b == '0);
        r_dbz    <= 1'b0;
        r_opnd   <= w_opDiv ? w_absB : w_absA;
        r_acc    <= {{WIDTH{1'b0}}, (w_opDiv ? w_absA : w_absB)};
      end else if (w_mthi) begin
        r_hi <= bus.i_a;
      end else if (w_mtlo) begin
        r_lo <= bus.i_a;
      end

      if (w_step) begin
        r_cnt <= r_cnt - CNT_W'(1);
        if (!r_isDiv) begin
          r_acc <= {w_addSum, r_acc[WIDTH-1:1]};
        end else if (w_diff[WIDTH]) begin
          r_acc <= {w_remShift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
        end else begin
          r_acc <= {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
        end
      end

      // With a zero divisor the remainder path already reproduces the dividend.
      if (w_finish) begin
        r_done <= 1'b1;
        if (r_isDiv) begin
          r_hi  <= w_remFix;
          r_lo  <= r_bZero ? '1 : w_quoFix;
          r_dbz <= r_bZero;
        end else begin
          {r_hi, r_lo} <= w_prodFix;
        end
      end
    end
  end

  assign bus.o_busy        = (r_state != IDLE);
  assign bus.o_done        = r_done;
  assign bus.o_div_by_zero = r_dbz;
  assign bus.o_hi          = r_hi;
  assign bus.o_lo          = r_lo;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: expected HI/LO are queued at issue time
// and compared when done pulses; status and corner cases are checked directly.
module tb_mips_muldiv_unit;

  localparam int WIDTH = 32;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          acceptCyc;
  } sbEntry_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   doneCount = 0;
  int   busyCount = 0;
  sbEntry_t sbQ[$];

  mips_muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  mips_muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic sbEntry_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    sbEntry_t    e;
    logic [63:0] prod;
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    e.tag = "";
    e.acceptCyc = 0;
    e.dbz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (op)
      3'd0: begin
        prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        {e.hi, e.lo} = prod;
      end
      3'd1: begin
        prod = {32'b0, a} * {32'b0, b};
        {e.hi, e.lo} = prod;
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
          e.dbz = 1'b1;
        end else if (op == 3'd2) begin
          sa = $signed(a);
          sb = $signed(b);
          q = sa / sb;
          r = sa % sb;
          e.lo = q[31:0];
          e.hi = r[31:0];
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  // Scoreboard consumer: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    sbEntry_t e;
    if (bus.o_busy) busyCount++;
    if (rst_n && bus.o_done) begin
      doneCount++;
      if (sbQ.size() == 0) begin
        checkOutput("spuriousDone", 64'd1, 64'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput({e.tag, ".hi"}, {32'b0, bus.o_hi}, {32'b0, e.hi});
        checkOutput({e.tag, ".lo"}, {32'b0, bus.o_lo}, {32'b0, e.lo});
        checkOutput({e.tag, ".dbz"}, {63'b0, bus.o_div_by_zero}, {63'b0, e.dbz});
        checkOutput({e.tag, ".latency"}, 64'(cyc - e.acceptCyc), 64'(WIDTH + 1));
      end
    end
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input bit doPush, input bit withFlush, input string tag);
    sbEntry_t e;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_flush = withFlush;
    if (doPush) begin
      e = model(op, a, b);
      e.tag = tag;
      e.acceptCyc = cyc + 1;
      sbQ.push_back(e);
    end
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_a     = $urandom;
    bus.i_b     = $urandom;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (sbQ.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbQ.size() != 0) begin
      checkOutput("timeout", 64'd0, 64'd1);
      sbQ.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int doneBefore;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n       = 1'b0;
    bus.i_start = 1'b0;
    bus.i_op    = '0;
    bus.i_a     = '0;
    bus.i_b     = '0;
    bus.i_flush = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst.hi",   {32'b0, bus.o_hi}, 64'd0);
    checkOutput("rst.lo",   {32'b0, bus.o_lo}, 64'd0);
    checkOutput("rst.busy", {63'b0, bus.o_busy}, 64'd0);
    checkOutput("rst.done", {63'b0, bus.o_done}, 64'd0);
    checkOutput("rst.dbz",  {63'b0, bus.o_div_by_zero}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, "multuMax");
    waitIdle();

    busyCount = 0;
    applyStimulus(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0, "multNeg");
    waitIdle();
    checkOutput("multNeg.busyCycles", 64'(busyCount), 64'd33);

    applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "divNeg7");
    waitIdle();
    applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "divuNeg7");
    waitIdle();

    applyStimulus(3'd3, 32'h1234_5678, 32'd0, 1'b1, 1'b0, "divuZero");
    waitIdle();
    applyStimulus(3'd1, 32'd2, 32'd3, 1'b1, 1'b1, "multu2x3");
    waitIdle();
    applyStimulus(3'd2, 32'h8765_4321, 32'd0, 1'b1, 1'b0, "divZeroNeg");
    waitIdle();

    applyStimulus(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, "mthi");
    checkOutput("mthi.hi",   {32'b0, bus.o_hi}, 64'hDEAD_BEEF);
    checkOutput("mthi.busy", {63'b0, bus.o_busy}, 64'd0);
    applyStimulus(3'd5, 32'h1357_9BDF, 32'd0, 1'b0, 1'b0, "mtlo");
    checkOutput("mtlo.lo",   {32'b0, bus.o_lo}, 64'h1357_9BDF);
    applyStimulus(3'd6, 32'h0BAD_0BAD, 32'd0, 1'b0, 1'b0, "reserved");
    checkOutput("reserved.hi",   {32'b0, bus.o_hi}, 64'hDEAD_BEEF);
    checkOutput("reserved.lo",   {32'b0, bus.o_lo}, 64'h1357_9BDF);
    checkOutput("reserved.busy", {63'b0, bus.o_busy}, 64'd0);

    doneBefore = doneCount;
    applyStimulus(3'd0, 32'h0000_1234, 32'h0000_5678, 1'b0, 1'b0, "flushed");
    repeat (8) @(negedge clk);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    checkOutput("flush.busy", {63'b0, bus.o_busy}, 64'd0);
    repeat (40) @(negedge clk);
    checkOutput("flush.hi",   {32'b0, bus.o_hi}, 64'hDEAD_BEEF);
    checkOutput("flush.lo",   {32'b0, bus.o_lo}, 64'h1357_9BDF);
    checkOutput("flush.noDone", 64'(doneCount - doneBefore), 64'd0);

    doneBefore = doneCount;
    applyStimulus(3'd1, 32'd2, 32'd3, 1'b1, 1'b0, "busyFirst");
    repeat (4) @(negedge clk);
    applyStimulus(3'd3, 32'd100, 32'd7, 1'b0, 1'b0, "ignored");
    waitIdle();
    repeat (40) @(negedge clk);
    checkOutput("busyStart.doneCount", 64'(doneCount - doneBefore), 64'd1);

    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 5) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
      applyStimulus(rop, ra, rb, 1'b1, 1'b0, $sformatf("rand%0d", i));
      waitIdle();
    end

    applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "divOverflow");
    waitIdle();

    applyStimulus(3'd2, 32'h7654_3210, 32'd13, 1'b1, 1'b0, "divReset");
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sbQ.delete();
    checkOutput("midRst.hi",   {32'b0, bus.o_hi}, 64'd0);
    checkOutput("midRst.lo",   {32'b0, bus.o_lo}, 64'd0);
    checkOutput("midRst.busy", {63'b0, bus.o_busy}, 64'd0);
    checkOutput("midRst.done", {63'b0, bus.o_done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("postRst.busy", {63'b0, bus.o_busy}, 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
